// File: rtl/countdown_timer.sv
// MM:SS:CC down-counter with load/start/pause and a blinking alarm at 00:00:00.
// Drives six active-low seven-segment digits from the registered time fields.
module countdown_timer #(
    parameter int CLOCK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_stop,
    input  logic       load,
    input  logic [6:0] set_min,
    input  logic [5:0] set_sec,
    output logic [6:0] minutes,
    output logic [5:0] seconds,
    output logic [6:0] centis,
    output logic       running,
    output logic       alarm,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);

    localparam int TICK = CLOCK_FREQ / 100;
    localparam int HALF = CLOCK_FREQ / 2;
    localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int BW   = $clog2(2 * HALF);
    localparam logic [PW-1:0] TICK_LAST  = PW'(TICK - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(2 * HALF - 1);
    localparam logic [BW-1:0] BLINK_HALF = BW'(HALF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_ALARM  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic [6:0]    cs_q, cs_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          running_q, running_d;
    logic          alarm_q, alarm_d;

    logic [6:0] dec_min_s, dec_cs_s, ld_min_s;
    logic [5:0] dec_sec_s, ld_sec_s;
    logic       dec_zero_s, time_zero_s, blank_s;

    function automatic logic [6:0] seg7(input logic [6:0] d);
        case (d)
            7'd0:    seg7 = 7'h40;
            7'd1:    seg7 = 7'h79;
            7'd2:    seg7 = 7'h24;
            7'd3:    seg7 = 7'h30;
            7'd4:    seg7 = 7'h19;
            7'd5:    seg7 = 7'h12;
            7'd6:    seg7 = 7'h02;
            7'd7:    seg7 = 7'h78;
            7'd8:    seg7 = 7'h00;
            7'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Two-digit decode: upper seven bits are the tens digit.
    function automatic logic [13:0] dec2seg(input logic [6:0] v);
        dec2seg = {seg7(v / 7'd10), seg7(v % 7'd10)};
    endfunction

    // One-centisecond decrement with borrow, plus clamped load values.
    always_comb begin
        if (cs_q != 7'd0) begin
            dec_cs_s  = cs_q - 7'd1;
            dec_sec_s = sec_q;
            dec_min_s = min_q;
        end else if (sec_q != 6'd0) begin
            dec_cs_s  = 7'd99;
            dec_sec_s = sec_q - 6'd1;
            dec_min_s = min_q;
        end else begin
            dec_cs_s  = 7'd99;
            dec_sec_s = 6'd59;
            dec_min_s = min_q - 7'd1;
        end
        dec_zero_s  = (dec_min_s == 7'd0) && (dec_sec_s == 6'd0) && (dec_cs_s == 7'd0);
        time_zero_s = (min_q == 7'd0) && (sec_q == 6'd0) && (cs_q == 7'd0);
        ld_min_s    = (set_min > 7'd99) ? 7'd99 : set_min;
        ld_sec_s    = (set_sec > 6'd59) ? 6'd59 : set_sec;
    end

    // Next-state logic; load outranks start_stop everywhere it is accepted.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        cs_d    = cs_q;
        presc_d = presc_q;
        blink_d = blink_q;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    min_d   = ld_min_s;
                    sec_d   = ld_sec_s;
                    cs_d    = 7'd0;
                    presc_d = '0;
                end else if (start_stop && !time_zero_s) begin
                    state_d = S_RUN;
                    presc_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (start_stop) begin
                    state_d = S_PAUSED;
                end else if (presc_q == TICK_LAST) begin
                    presc_d = '0;
                    min_d   = dec_min_s;
                    sec_d   = dec_sec_s;
                    cs_d    = dec_cs_s;
                    if (dec_zero_s) begin
                        state_d = S_ALARM;
                        blink_d = '0;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            S_PAUSED: begin
                if (load) begin
                    state_d = S_IDLE;
                    min_d   = ld_min_s;
                    sec_d   = ld_sec_s;
                    cs_d    = 7'd0;
                    presc_d = '0;
                end else if (start_stop) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_PAUSED;
                end
            end
            S_ALARM: begin
                if (load) begin
                    state_d = S_IDLE;
                    min_d   = ld_min_s;
                    sec_d   = ld_sec_s;
                    cs_d    = 7'd0;
                    presc_d = '0;
                end else if (start_stop) begin
                    state_d = S_IDLE;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                end else begin
                    blink_d = blink_q + {{(BW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        running_d = (state_d == S_RUN);
        alarm_d   = (state_d == S_ALARM);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            min_q     <= 7'd0;
            sec_q     <= 6'd0;
            cs_q      <= 7'd0;
            presc_q   <= '0;
            blink_q   <= '0;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            cs_q      <= cs_d;
            presc_q   <= presc_d;
            blink_q   <= blink_d;
            running_q <= running_d;
            alarm_q   <= alarm_d;
        end
    end

    // Display path: decode registered time, blank during the alarm's off phase.
    always_comb begin
        blank_s = alarm_q && (blink_q >= BLINK_HALF);
        if (blank_s) begin
            {HEX1, HEX0} = {7'h7F, 7'h7F};
            {HEX3, HEX2} = {7'h7F, 7'h7F};
            {HEX5, HEX4} = {7'h7F, 7'h7F};
        end else begin
            {HEX1, HEX0} = dec2seg(cs_q);
            {HEX3, HEX2} = dec2seg({1'b0, sec_q});
            {HEX5, HEX4} = dec2seg(min_q);
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign centis  = cs_q;
    assign running = running_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: directed scenarios plus random traffic, compared each cycle
// against a model that tracks the remaining time as a single centisecond count.
module tb_countdown_timer;

    localparam int CF   = 1000;
    localparam int TICK = CF / 100;
    localparam int HALF = CF / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_stop = 1'b0;
    logic       load = 1'b0;
    logic [6:0] set_min = 7'd0;
    logic [5:0] set_sec = 6'd0;
    logic [6:0] minutes, centis;
    logic [5:0] seconds;
    logic       running, alarm;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int tests = 0;
    int fails = 0;

    // Model: remaining centiseconds, mode (0 idle, 1 run, 2 paused, 3 alarm),
    // RUN cycles since the last decrement, and cycles since alarm entry.
    int m_rem = 0;
    int m_mode = 0;
    int m_phase = 0;
    int m_acnt = 0;

    logic [6:0]  seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [63:0] zeros_pat;
    logic [63:0] blank_pat;

    countdown_timer #(.CLOCK_FREQ(CF)) dut (
        .clk(clk), .rst_n(rst_n), .start_stop(start_stop), .load(load),
        .set_min(set_min), .set_sec(set_sec),
        .minutes(minutes), .seconds(seconds), .centis(centis),
        .running(running), .alarm(alarm),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hex_obs();
        return {22'd0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    function automatic logic [63:0] hex_exp();
        int mi, se, cs;
        mi = m_rem / 6000;
        se = (m_rem / 100) % 60;
        cs = m_rem % 100;
        if (m_mode == 3 && m_acnt >= HALF) return blank_pat;
        return {22'd0, seg_tbl[mi / 10], seg_tbl[mi % 10], seg_tbl[se / 10],
                seg_tbl[se % 10], seg_tbl[cs / 10], seg_tbl[cs % 10]};
    endfunction

    task automatic model_update();
        int lm, ls;
        lm = (int'(set_min) > 99) ? 99 : int'(set_min);
        ls = (int'(set_sec) > 59) ? 59 : int'(set_sec);
        if (!rst_n) begin
            m_rem = 0; m_mode = 0; m_phase = 0; m_acnt = 0;
        end else if (load && m_mode != 1) begin
            m_rem = lm * 6000 + ls * 100; m_mode = 0; m_phase = 0;
        end else if (m_mode == 0) begin
            if (start_stop && m_rem > 0) begin m_mode = 1; m_phase = 0; end
        end else if (m_mode == 1) begin
            if (start_stop) m_mode = 2;
            else begin
                m_phase++;
                if (m_phase == TICK) begin
                    m_phase = 0;
                    m_rem--;
                    if (m_rem == 0) begin m_mode = 3; m_acnt = 0; end
                end
            end
        end else if (m_mode == 2) begin
            if (start_stop) m_mode = 1;
        end else begin
            if (start_stop) m_mode = 0;
            else m_acnt = (m_acnt + 1) % (2 * HALF);
        end
    endtask

    task automatic check_model();
        chk("model_min", 64'(minutes), 64'(m_rem / 6000));
        chk("model_sec", 64'(seconds), 64'((m_rem / 100) % 60));
        chk("model_cs", 64'(centis), 64'(m_rem % 100));
        chk("model_running", 64'(running), 64'(m_mode == 1));
        chk("model_alarm", 64'(alarm), 64'(m_mode == 3));
        chk("model_hex", hex_obs(), hex_exp());
    endtask

    task automatic step(input logic ld, input logic ss, input logic [6:0] m, input logic [5:0] s);
        load = ld; start_stop = ss; set_min = m; set_sec = s;
        @(posedge clk);
        model_update();
        #1;
        check_model();
        load = 1'b0; start_stop = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'd0, 6'd0);
    endtask

    task automatic chk_time(input string tag, input int mi, input int se, input int cs);
        chk({tag, "_min"}, 64'(minutes), 64'(mi));
        chk({tag, "_sec"}, 64'(seconds), 64'(se));
        chk({tag, "_cs"}, 64'(centis), 64'(cs));
    endtask

    initial begin
        zeros_pat = {22'd0, {6{7'h40}}};
        blank_pat = {22'd0, {6{7'h7F}}};
        #2;

        // Reset state
        rst_n = 1'b0;
        step(1'b0, 1'b0, 7'd0, 6'd0);
        chk_time("reset", 0, 0, 0);
        chk("reset_running", 64'(running), 64'd0);
        chk("reset_alarm", 64'(alarm), 64'd0);
        chk("reset_hex", hex_obs(), zeros_pat);
        rst_n = 1'b1;

        // Basic countdown and alarm blink
        step(1'b1, 1'b0, 7'd0, 6'd2);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        idle(10);
        chk_time("basic_first", 0, 1, 99);
        idle(1990);
        chk_time("basic_end", 0, 0, 0);
        chk("basic_alarm", 64'(alarm), 64'd1);
        chk("basic_running", 64'(running), 64'd0);
        idle(499);
        chk("blink_499", hex_obs(), zeros_pat);
        idle(1);
        chk("blink_500", hex_obs(), blank_pat);
        idle(499);
        chk("blink_999", hex_obs(), blank_pat);
        idle(1);
        chk("blink_1000", hex_obs(), zeros_pat);
        idle(499);
        chk("blink_1499", hex_obs(), zeros_pat);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        chk("alarm_exit", 64'(alarm), 64'd0);

        // Borrow chain
        step(1'b1, 1'b0, 7'd1, 6'd0);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        idle(10);
        chk_time("borrow", 0, 59, 99);
        step(1'b0, 1'b1, 7'd0, 6'd0);

        // Pause/resume keeps sub-centisecond phase
        step(1'b1, 1'b0, 7'd0, 6'd1);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        idle(25);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        chk_time("pause", 0, 0, 98);
        idle(100);
        chk_time("pause_hold", 0, 0, 98);
        chk("pause_running", 64'(running), 64'd0);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        idle(4);
        chk_time("resume_4", 0, 0, 98);
        idle(1);
        chk_time("resume_5", 0, 0, 97);
        step(1'b0, 1'b1, 7'd0, 6'd0);

        // Clamp and priority
        step(1'b1, 1'b0, 7'd120, 6'd63);
        chk_time("clamp", 99, 59, 0);
        step(1'b1, 1'b1, 7'd3, 6'd4);
        chk_time("prio", 3, 4, 0);
        chk("prio_running", 64'(running), 64'd0);
        idle(3);
        chk_time("prio_idle", 3, 4, 0);
        step(1'b1, 1'b0, 7'd0, 6'd0);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        chk("zero_start_running", 64'(running), 64'd0);

        // Reset mid-run
        step(1'b1, 1'b0, 7'd0, 6'd1);
        step(1'b0, 1'b1, 7'd0, 6'd0);
        idle(500);
        chk_time("prereset", 0, 0, 50);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 7'd0, 6'd0);
        rst_n = 1'b1;
        chk_time("midrun_reset", 0, 0, 0);
        chk("midrun_running", 64'(running), 64'd0);
        chk("midrun_alarm", 64'(alarm), 64'd0);
        idle(30);
        chk_time("after_reset", 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [6:0] m;
            logic [5:0] s;
            r = int'($urandom_range(0, 99));
            m = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(0, 127)) : 7'd0;
            s = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 2));
            rst_n = ($urandom_range(0, 999) != 0);
            step(r < 3, (r >= 2) && (r < 5), m, s);
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
